// File: rtl/serial_bit_source.sv
// -----------------------------------------------------------------------------
// serial_bit_source
//
// Parallel-to-serial bit-stream generator. Accepts WIDTH-bit words over a
// valid/ready handshake and plays them out one bit per consumed cycle on a
// single serial line. It is intended to feed a serial sequence detector.
//
// Handshake semantics (both sides):
//   - Upstream load: a word transfers on a rising clk edge where
//     load_valid & load_ready are both 1. Once load_valid is raised, upstream
//     holds load_valid and data_in stable until that edge. load_ready is
//     combinational and is also 1 during the final bit transfer of a word,
//     so back-to-back words stream with no gap cycle.
//   - Downstream bits: a bit transfers on a rising clk edge where
//     bit_valid & shift_en are both 1. With shift_en=0, bit_out, last_bit
//     and the bit counter hold for as long as needed.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst        in   asynchronous, active-high reset
//   load_valid in   upstream word available on data_in
//   load_ready out  block can accept a word this cycle
//   data_in    in   WIDTH-bit parallel word, captured on an accepted load
//   shift_en   in   downstream consumes bit_out this cycle
//   bit_out    out  current serial bit
//   bit_valid  out  bit_out is meaningful
//   last_bit   out  bit_out is the final bit of the current word
//   busy       out  a word is in flight (FSM in SHIFT); this output is also
//                   the externally visible copy of the FSM state
//
// Parameters:
//   WIDTH      word length in bits, 2..32
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// -----------------------------------------------------------------------------
module serial_bit_source #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               load_accept;
    logic               bit_xfer;
    logic [WIDTH-1:0]   shreg_next;

    // Handshake events for this cycle.
    assign bit_xfer    = bit_valid & shift_en;
    assign load_accept = load_valid & load_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Leaving SHIFT only on the final bit transfer; a load
                // accepted on that same edge keeps us streaming.
                if (bit_xfer && last_bit && !load_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    always_comb begin
        bit_valid  = (state_q == SHIFT);
        busy       = (state_q == SHIFT);
        last_bit   = (state_q == SHIFT) && (cnt_q == '0);
        // Held low during reset so nothing is accepted while rst is asserted.
        load_ready = !rst && ((state_q == IDLE) ||
                              ((state_q == SHIFT) && shift_en && (cnt_q == '0)));
        bit_out    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register and bit counter
    // -------------------------------------------------------------------------
    always_comb begin
        shreg_next = shreg_q;
        if (MSB_FIRST) begin
            shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_accept) begin
            // A load wins over the final-bit shift on the same edge.
            shreg_q <= data_in;
            cnt_q   <= CNT_W'(WIDTH - 1);
        end else if (bit_xfer) begin
            shreg_q <= shreg_next;
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_source
//
// Directed bench for serial_bit_source. Two instances: an 8-bit MSB-first
// unit for most steps and a 4-bit LSB-first unit for the bit-order step.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_serial_bit_source;

    logic       clk;
    logic       rst;

    // 8-bit, MSB-first instance
    logic       load_valid;
    logic       load_ready;
    logic [7:0] data_in;
    logic       shift_en;
    logic       bit_out;
    logic       bit_valid;
    logic       last_bit;
    logic       busy;

    // 4-bit, LSB-first instance
    logic       load_valid4;
    logic       load_ready4;
    logic [3:0] data_in4;
    logic       shift_en4;
    logic       bit_out4;
    logic       bit_valid4;
    logic       last_bit4;
    logic       busy4;

    int compared;
    int mismatched;

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .shift_en   (shift_en),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .last_bit   (last_bit),
        .busy       (busy)
    );

    serial_bit_source #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid4),
        .load_ready (load_ready4),
        .data_in    (data_in4),
        .shift_en   (shift_en4),
        .bit_out    (bit_out4),
        .bit_valid  (bit_valid4),
        .last_bit   (last_bit4),
        .busy       (busy4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d",
                 compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks one displayed bit of the 8-bit unit.
    task automatic chk_bit(input string tag, input logic exp_bit, input logic exp_last);
        chk({tag, " bit_valid"}, bit_valid, 1'b1);
        chk({tag, " bit_out"},   bit_out,   exp_bit);
        chk({tag, " last_bit"},  last_bit,  exp_last);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " bit_valid"},  bit_valid,  1'b0);
        chk({tag, " busy"},       busy,       1'b0);
        chk({tag, " load_ready"}, load_ready, 1'b1);
    endtask

    initial begin
        logic [7:0]  exp8;
        logic [15:0] exp16;
        logic [5:0]  exp6;
        logic [3:0]  exp4;

        compared    = 0;
        mismatched  = 0;
        rst         = 1'b1;
        load_valid  = 1'b0;
        data_in     = 8'h00;
        shift_en    = 1'b0;
        load_valid4 = 1'b0;
        data_in4    = 4'h0;
        shift_en4   = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        chk("rst bit_valid",  bit_valid,  1'b0);
        chk("rst busy",       busy,       1'b0);
        chk("rst bit_out",    bit_out,    1'b0);
        chk("rst last_bit",   last_bit,   1'b0);
        chk("rst load_ready", load_ready, 1'b0);
        chk("rst4 load_ready", load_ready4, 1'b0);
        rst = 1'b0;
        #1;
        chk("post-rst load_ready", load_ready, 1'b1);

        // ---- step 1: 8'hB4 MSB first ----
        exp8       = 8'b1011_0100;
        load_valid = 1'b1;
        data_in    = 8'hB4;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        data_in    = 8'h00;   // must not disturb the word in flight
        for (int i = 0; i < 8; i++) begin
            chk_bit($sformatf("s1[%0d]", i), exp8[7-i], (i == 7));
            chk($sformatf("s1[%0d] busy", i), busy, 1'b1);
            tick();
        end
        chk_idle("s1 end");

        // ---- step 2: 8'hA5 then 8'h3C back to back ----
        exp16      = 16'b1010_0101_0011_1100;
        load_valid = 1'b1;
        data_in    = 8'hA5;
        tick();
        data_in    = 8'h3C;   // next word presented, load_valid kept high
        for (int i = 0; i < 16; i++) begin
            chk_bit($sformatf("s2[%0d]", i), exp16[15-i], (i == 7) || (i == 15));
            if (i < 7) begin
                chk($sformatf("s2[%0d] load_ready", i), load_ready, 1'b0);
            end
            if (i == 7) begin
                chk("s2 overlap load_ready", load_ready, 1'b1);
            end
            tick();
            if (i == 7) begin
                load_valid = 1'b0;
            end
        end
        chk_idle("s2 end");

        // ---- step 3: 8'hF0 with 3-cycle stall after two bits ----
        load_valid = 1'b1;
        data_in    = 8'hF0;
        tick();
        load_valid = 1'b0;
        chk_bit("s3[0]", 1'b1, 1'b0);
        tick();
        chk_bit("s3[1]", 1'b1, 1'b0);
        tick();
        shift_en = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_bit($sformatf("s3 stall%0d", i), 1'b1, 1'b0);
            chk($sformatf("s3 stall%0d load_ready", i), load_ready, 1'b0);
            chk($sformatf("s3 stall%0d busy", i), busy, 1'b1);
            tick();
        end
        shift_en = 1'b1;
        exp6     = 6'b11_0000;
        for (int i = 0; i < 6; i++) begin
            chk_bit($sformatf("s3 rest[%0d]", i), exp6[5-i], (i == 5));
            tick();
        end
        chk_idle("s3 end");

        // ---- step 4: 8'h81, async reset after 4 bits, then 8'h01 ----
        exp8       = 8'b1000_0001;
        load_valid = 1'b1;
        data_in    = 8'h81;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_bit($sformatf("s4[%0d]", i), exp8[7-i], 1'b0);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("s4 async bit_valid",  bit_valid,  1'b0);
        chk("s4 async busy",       busy,       1'b0);
        chk("s4 async bit_out",    bit_out,    1'b0);
        chk("s4 async last_bit",   last_bit,   1'b0);
        chk("s4 async load_ready", load_ready, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        chk_idle("s4 after rst");
        tick();
        chk("s4 no resume bit_valid", bit_valid, 1'b0);
        exp8       = 8'b0000_0001;
        load_valid = 1'b1;
        data_in    = 8'h01;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_bit($sformatf("s4b[%0d]", i), exp8[7-i], (i == 7));
            tick();
        end
        chk_idle("s4b end");

        // ---- step 5: WIDTH=4 LSB first, 4'b0110 -> 0,1,1,0 ----
        exp4        = 4'b0110;
        chk("s5 idle load_ready", load_ready4, 1'b1);
        load_valid4 = 1'b1;
        data_in4    = 4'b0110;
        shift_en4   = 1'b1;
        tick();
        load_valid4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s5[%0d] bit_valid", i), bit_valid4, 1'b1);
            chk($sformatf("s5[%0d] bit_out", i),   bit_out4,   exp4[i]);
            chk($sformatf("s5[%0d] last_bit", i),  last_bit4,  (i == 3));
            tick();
        end
        chk("s5 end bit_valid",  bit_valid4,  1'b0);
        chk("s5 end busy",       busy4,       1'b0);
        chk("s5 end load_ready", load_ready4, 1'b1);

        // ---- step 6: load pulse mid-word is ignored ----
        exp8       = 8'b1100_0011;
        load_valid = 1'b1;
        data_in    = 8'hC3;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                load_valid = 1'b1;
                data_in    = 8'hFF;
                #1;
                chk("s6 pulse load_ready", load_ready, 1'b0);
            end
            chk_bit($sformatf("s6[%0d]", i), exp8[7-i], (i == 7));
            tick();
            if (i == 3) begin
                load_valid = 1'b0;
                data_in    = 8'h00;
            end
        end
        chk_idle("s6 end");
        tick();
        chk("s6 stays idle", bit_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
Parallel-to-serial bit-stream generator placed directly upstream of the Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits them one bit per consumed cycle on a single serial line, with a valid strobe and a word-boundary flag.
- Downstream stall (shift_en) holds the current bit. Back-to-back words stream with no gap cycle.

Parameters:
- WIDTH, 8, word length in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  upstream word available on data_in.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  parallel word, sampled on an accepted load.
- shift_en  input  1  downstream consumes bit_out this cycle.
- bit_out  output  1  current serial bit.
- bit_valid  output  1  bit_out is meaningful.
- last_bit  output  1  bit_out is the final bit of the current word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, shift register=0, bit counter=0.
  - bit_out=0, bit_valid=0, last_bit=0, busy=0.
  - load_ready forced 0 while rst=1.
- States:
  - IDLE: bit_valid=0, busy=0, load_ready=1.
  - SHIFT: bit_valid=1, busy=1.
- Load accept: rising edge with load_valid & load_ready.
  - data_in is captured into the shift register and the counter is set to WIDTH-1.
  - Next state is SHIFT. The first bit appears on bit_out the cycle after accept (1-cycle latency).
- Bit transfer: rising edge with bit_valid & shift_en.
  - Shift register advances one position: left if MSB_FIRST, else right; zero fill.
  - Counter decrements.
- Stall: if shift_en=0 while bit_valid=1, bit_out, last_bit and counter hold unchanged for any number of cycles.
- Flags and outputs:
  - last_bit = bit_valid & (counter==0).
  - bit_out = shift register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
- load_ready = IDLE | (bit_valid & shift_en & last_bit). This is combinational and allows acceptance during the final bit transfer.
- Final bit transfer with no load that cycle: state goes to IDLE, bit_valid=0 the next cycle.
- Final bit transfer plus simultaneous accepted load:
  - New word is captured and state stays SHIFT.
  - The first bit of the new word appears the next cycle with no idle gap.
- Load not accepted: load_valid while load_ready=0 has no effect; upstream must hold data_in and load_valid until accepted.
- data_in changes outside an accept edge have no effect on bit_out.
- Reset mid-word: the in-flight word is discarded, the outputs take their reset values immediately, and no partial word resumes.
- Throughput: with shift_en held at 1, one word every WIDTH cycles.

Test Plan:
1. Reset, then load 8'hB4 (MSB_FIRST=1), shift_en=1 -> bit_out sequence 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting 1 cycle after accept. last_bit=1 only on the 8th. bit_valid=0 afterwards.
2. Loads 8'hA5 then 8'h3C, load_valid held high -> second accept coincides with the last bit of 8'hA5. 16 contiguous valid bits 10100101 00111100 with no bit_valid gap.
3. Load 8'hF0, drop shift_en for 3 cycles after the 2nd bit -> bit_out=1 and the counter stay frozen for 3 cycles. The remaining bits 1,1,0,0,0,0 follow unchanged. load_ready=0 throughout the stall.
4. Load 8'h81, assert rst asynchronously (mid-cycle) after 4 bits -> bit_valid, busy and bit_out drop to 0 immediately without waiting for a clock edge. After release, load_ready=1 and a new load 8'h01 streams correctly.
5. MSB_FIRST=0, WIDTH=4, load 4'b0110 -> bit_out 0,1,1,0 (LSB first), last_bit on the 4th.
6. load_valid pulsed for 1 cycle while busy (mid-word, shift_en=1) -> ignored. The in-flight word completes unaltered and the block returns to IDLE.
